// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate D-cache controller; drives the M-stage memory stall.
// Optional hit/miss counters are enabled by defining DMEM_CACHE_STATS_EN.
`timescale 1ns/1ps
module dmem_cache_ctrl #(
  parameter int SETS   = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [31:0]       wdataM,
  output logic [31:0]       rdataM,
  output logic              stall,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [31:0]       mm_wdata,
  input  logic              mm_ready,
  input  logic [31:0]       mm_rdata
`ifdef DMEM_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESUME} state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tagM;
  logic             hit;
  logic             fill_we, store_we, inval, hit_evt, miss_evt;
  logic             unused_addr_lsb;

  assign off             = addrM[OFF_W+1:2];
  assign idx             = addrM[OFF_W+2 +: IDX_W];
  assign tagM            = addrM[ADDR_W-1 -: TAG_W];
  assign hit             = valid_q[idx] && (tag_q[idx] == tagM);
  assign unused_addr_lsb = ^addrM[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    mm_req   = 1'b0;
    mm_we    = 1'b0;
    mm_addr  = '0;
    mm_wdata = '0;
    rdataM   = '0;
    fill_we  = 1'b0;
    store_we = 1'b0;
    inval    = 1'b0;
    hit_evt  = 1'b0;
    miss_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_writeM) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (mem_readM) begin
          if (hit) begin
            rdataM  = data_q[idx][off];
            hit_evt = 1'b1;
          end else begin
            stall    = 1'b1;
            state_d  = REFILL;
            cnt_d    = '0;
            inval    = 1'b1;
            miss_evt = 1'b1;
          end
        end
      end
      REFILL: begin
        stall   = 1'b1;
        mm_req  = 1'b1;
        mm_addr = {tagM, idx, cnt_q, 2'b00};
        if (mm_ready) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) state_d = RESUME;
        end
      end
      WRITE: begin
        stall    = 1'b1;
        mm_req   = 1'b1;
        mm_we    = 1'b1;
        mm_addr  = {addrM[ADDR_W-1:2], 2'b00};
        mm_wdata = wdataM;
        if (mm_ready) begin
          store_we = hit;
          state_d  = RESUME;
        end
      end
      RESUME: begin
        // Line is known resident here, so a pending load is served directly.
        if (mem_readM) rdataM = data_q[idx][off];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, regardless of the M-stage inputs.
    if (rst) begin
      stall    = 1'b0;
      mm_req   = 1'b0;
      mm_we    = 1'b0;
      mm_addr  = '0;
      mm_wdata = '0;
      rdataM   = '0;
      hit_evt  = 1'b0;
      miss_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (inval) valid_q[idx] <= 1'b0;
      if (fill_we && cnt_q == LAST_WORD) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[idx][cnt_q] <= mm_rdata;
    if (fill_we && cnt_q == LAST_WORD) tag_q[idx] <= tagM;
    if (store_we) data_q[idx][off] <= wdataM;
  end

`ifdef DMEM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt | miss_evt;
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Directed bench for dmem_cache_ctrl; main memory returns each word's own address as its data.
`timescale 1ns/1ps
module tb_dmem_cache_ctrl;
  localparam int SETS   = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_readM, mem_writeM;
  logic [ADDR_W-1:0] addrM;
  logic [31:0]       wdataM;
  logic [31:0]       rdataM;
  logic              stall, mm_req, mm_we;
  logic [ADDR_W-1:0] mm_addr;
  logic [31:0]       mm_wdata;
  logic              mm_ready;
  logic [31:0]       mm_rdata;
`ifdef DMEM_CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ready_delay = 0;
  int wait_cnt = 0;
  logic [31:0] data_q_exp[$];
  logic [31:0] addr_q_exp[$];

  dmem_cache_ctrl #(.SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .addrM(addrM), .wdataM(wdataM), .rdataM(rdataM), .stall(stall),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_ready(mm_ready), .mm_rdata(mm_rdata)
`ifdef DMEM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory accepts after ready_delay waiting cycles; delay 0 means ready held high.
  assign mm_ready = (ready_delay == 0) ? 1'b1 : (mm_req && wait_cnt == ready_delay);
  assign mm_rdata = mm_addr;
  always @(posedge clk) wait_cnt <= mm_req ? wait_cnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input bit miss, input string tag);
    int reqs;
    bit served;
    reqs = 0;
    served = 0;
    mem_readM = 1'b1;
    addrM = a;
    data_q_exp.push_back(exp);
    if (miss)
      for (int w = 0; w < WORDS; w++) addr_q_exp.push_back((a & 32'hFFFF_FFF0) + 32'(w * 4));
    @(negedge clk);
    check({tag, "_first_stall"}, {31'd0, stall}, {31'd0, miss});
    for (int c = 0; c < 40 && !served; c++) begin
      if (c > 0) @(negedge clk);
      if (stall) begin
        if (mm_req) begin
          reqs++;
          if (mm_ready && addr_q_exp.size() > 0) check({tag, "_mm_addr"}, mm_addr, addr_q_exp.pop_front());
        end
      end else begin
        check({tag, "_rdata"}, rdataM, data_q_exp.pop_front());
        check({tag, "_mm_req_off"}, {31'd0, mm_req}, 32'd0);
        served = 1;
      end
    end
    check({tag, "_served"}, {31'd0, served}, 32'd1);
    check({tag, "_refill_cycles"}, reqs, miss ? WORDS : 0);
    @(posedge clk); #1;
    mem_readM = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int delay, input string tag);
    int reqs;
    bit done;
    bit stable;
    reqs = 0;
    done = 0;
    stable = 1;
    ready_delay = delay;
    mem_writeM = 1'b1;
    addrM = a;
    wdataM = d;
    @(negedge clk);
    check({tag, "_first_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "_first_req"}, {31'd0, mm_req}, 32'd0);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (stall) begin
        if (mm_req) begin
          reqs++;
          if (!(mm_we === 1'b1 && mm_addr === a && mm_wdata === d)) stable = 0;
        end
      end else begin
        done = 1;
      end
    end
    check({tag, "_resumed"}, {31'd0, done}, 32'd1);
    check({tag, "_write_cycles"}, reqs, delay + 1);
    check({tag, "_we_addr_stable"}, {31'd0, stable}, 32'd1);
    @(posedge clk); #1;
    mem_writeM = 1'b0;
    ready_delay = 0;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    mem_readM = 1'b0;
    mem_writeM = 1'b0;
    addrM = '0;
    wdataM = '0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mm_req", {31'd0, mm_req}, 32'd0);
    check("rst_mm_we", {31'd0, mm_we}, 32'd0);
    check("rst_mm_addr", mm_addr, 32'd0);
    check("rst_mm_wdata", mm_wdata, 32'd0);
    check("rst_rdata", rdataM, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(32'h100, 32'h100, 1, "cold_load");
    do_load(32'h108, 32'h108, 0, "hit_after_fill");
    do_store(32'h104, 32'hDEADBEEF, 3, "store_hit");
`ifdef DMEM_CACHE_STATS_EN
    check("stats_hit_cnt", hit_cnt, 32'd1);
    check("stats_miss_cnt", miss_cnt, 32'd1);
`endif
    do_load(32'h104, 32'hDEADBEEF, 0, "load_after_store");

    do_store(32'h900, 32'h12345678, 0, "store_miss");
    do_load(32'h100, 32'h100, 0, "line_kept_after_store_miss");
    do_load(32'h100 + SETS * WORDS * 4, 32'h100 + SETS * WORDS * 4, 1, "conflict_load");
    do_load(32'h100, 32'h100, 1, "reload_after_evict");

    // Abort a refill at its third word with an asynchronous reset.
    mem_readM = 1'b1;
    addrM = 32'h300;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mm_req && mm_addr == 32'h308) found = 1;
    end
    check("abort_reached_word2", {31'd0, found}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_mm_req", {31'd0, mm_req}, 32'd0);
    check("abort_rdata", rdataM, 32'd0);
    mem_readM = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_load(32'h300, 32'h300, 1, "refill_after_abort");

    check("scoreboard_drained", data_q_exp.size() + addr_q_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
